// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_* valid/ready stream blocks.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ALWAYS = 2'd0;
    localparam logic [1:0] MODE_LFSR   = 2'd1;
    localparam logic [1:0] MODE_PERIOD = 2'd2;
    localparam logic [1:0] MODE_NEVER  = 2'd3;

    // Taps for x^16+x^14+x^13+x^11+1 in a left-shifting Fibonacci register
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    // The bit of the LFSR state used as the random ready gate
    localparam logic [15:0] LFSR_OUT_BIT = 16'h0001;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // An all-zero LFSR would lock up, so zero seeds become 1
    function automatic logic [15:0] fix_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable.
module pipe_lfsr16
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    input  logic        i_en,
    output logic [15:0] o_state
);

    // Load has priority over stepping so a restart always begins at the seed
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_state <= fix_seed(SEED);
        end else if (i_load) begin
            o_state <= fix_seed(i_seed);
        end else if (i_en) begin
            o_state <= lfsr_next(o_state);
        end
    end

endmodule

// File: rtl/pipe_sink.sv
// Stream sink: generates back-pressure, checks an incrementing data
// sequence and watches the valid/ready handshake for protocol violations.
module pipe_sink
    import pipe_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          CNT_W = 32,
    parameter logic [15:0] SEED  = DEFAULT_SEED
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_expect_start,
    input  logic [CNT_W-1:0] i_num_beats,
    input  logic [1:0]       i_mode,
    input  logic [7:0]       i_period,
    output logic [CNT_W-1:0] o_beat_cnt,
    output logic [15:0]      o_err_cnt,
    output logic [WIDTH-1:0] o_first_bad_data,
    output logic [WIDTH-1:0] o_first_bad_exp,
    output logic             o_proto_err,
    output logic             o_done
);

    state_t           state;
    logic [WIDTH-1:0] exp_data;
    logic [CNT_W-1:0] num_beats;
    logic [7:0]       pcnt;
    logic             pending;
    logic [WIDTH-1:0] pending_data;
    logic [15:0]      lfsr_q;
    logic             gate;
    logic             handshake;

    pipe_lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_load (i_start),
        .i_seed (SEED),
        .i_en   (state == RUN),
        .o_state(lfsr_q)
    );

    // Back-pressure gate chosen live from the mode input
    always_comb begin
        gate = 1'b0;
        case (i_mode)
            MODE_ALWAYS: gate = 1'b1;
            MODE_LFSR:   gate = |(lfsr_q & LFSR_OUT_BIT);
            MODE_PERIOD: gate = (pcnt == 8'd0);
            MODE_NEVER:  gate = 1'b0;
            default:     gate = 1'b0;
        endcase
    end

    assign o_rdy     = (state == RUN) & ~i_start & gate;
    assign handshake = i_vld & o_rdy;

    // Sequencer, data checker and protocol monitor in one state machine
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= IDLE;
            exp_data         <= '0;
            num_beats        <= '0;
            pcnt             <= 8'd0;
            pending          <= 1'b0;
            pending_data     <= '0;
            o_beat_cnt       <= '0;
            o_err_cnt        <= 16'd0;
            o_first_bad_data <= '0;
            o_first_bad_exp  <= '0;
            o_proto_err      <= 1'b0;
            o_done           <= 1'b0;
        end else if (i_start) begin
            state            <= RUN;
            exp_data         <= i_expect_start;
            num_beats        <= i_num_beats;
            pcnt             <= 8'd0;
            pending          <= 1'b0;
            o_beat_cnt       <= '0;
            o_err_cnt        <= 16'd0;
            o_first_bad_data <= '0;
            o_first_bad_exp  <= '0;
            o_proto_err      <= 1'b0;
            o_done           <= 1'b0;
        end else if (state == RUN) begin
            pcnt <= (pcnt >= i_period) ? 8'd0 : pcnt + 8'd1;
            if (pending && (!i_vld || (i_data != pending_data))) begin
                o_proto_err <= 1'b1;
            end
            if (handshake) begin
                o_beat_cnt <= o_beat_cnt + CNT_W'(1);
                exp_data   <= exp_data + WIDTH'(1);
                pending    <= 1'b0;
                if (i_data != exp_data) begin
                    if (o_err_cnt != 16'hFFFF) begin
                        o_err_cnt <= o_err_cnt + 16'd1;
                    end
                    if (o_err_cnt == 16'd0) begin
                        o_first_bad_data <= i_data;
                        o_first_bad_exp  <= exp_data;
                    end
                end
                if ((num_beats != '0) && ((o_beat_cnt + CNT_W'(1)) == num_beats)) begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end
            end else if (i_vld && !pending) begin
                pending      <= 1'b1;
                pending_data <= i_data;
            end
        end
    end

endmodule
